// File: rtl/ibuffer_mq_pkg.sv
// Shared defaults and bundle field layout for the multi-queue instruction buffer.
package ibuffer_mq_pkg;

    localparam int NUM_WARPS_DEF = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int INSTR_W_DEF   = 64;

    // Scoreboard-visible fields inside the opaque decoded bundle.
    localparam int F_VALID_BIT   = 0;
    localparam int F_DST_LSB     = 1;
    localparam int F_SRC0_LSB    = 7;
    localparam int F_SRC1_LSB    = 13;
    localparam int F_REG_W       = 6;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/ibuffer_mq_warp_fifo.sv
// Per-warp instruction queue: two ordered pushes and one pop per cycle, flush, overflow pulse.
module ibuffer_mq_warp_fifo
    import ibuffer_mq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push0,
    input  logic               push1,
    input  logic [INSTR_W-1:0] data0,
    input  logic [INSTR_W-1:0] data1,
    input  logic               pop,
    input  logic               flush,
    output logic               head_valid,
    output logic [INSTR_W-1:0] head_data,
    output logic [CW-1:0]      count,
    output logic               ovf
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr, wr_b;
    logic [CW-1:0]      cnt_a;
    logic               acc0, acc1, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Room is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
    always_comb begin
        acc0   = push0 && !flush && (count < CW'(DEPTH));
        cnt_a  = count + CW'(acc0);
        acc1   = push1 && !flush && (cnt_a < CW'(DEPTH));
        ovf    = !flush && ((push0 && !acc0) || (push1 && !acc1));
        wr_b   = acc0 ? ptr_inc(wr_ptr) : wr_ptr;
        pop_ok = pop && head_valid && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            wr_ptr <= acc1 ? ptr_inc(wr_b) : wr_b;
            count  <= count + CW'(acc0) + CW'(acc1) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= data0;
        if (acc1) mem[wr_b]   <= data1;
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/ibuffer_mq.sv
// Multi-queue instruction buffer: per-warp FIFOs, round-robin issue arbiter, stallable issue register.
module ibuffer_mq
    import ibuffer_mq_pkg::*;
#(
    parameter int NUM_WARPS    = NUM_WARPS_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int INSTR_W      = INSTR_W_DEF,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr0_valid,
    input  logic [LOGNUM_WARPS-1:0]      wr0_warp,
    input  logic [INSTR_W-1:0]           wr0_data,
    input  logic                         wr1_valid,
    input  logic [LOGNUM_WARPS-1:0]      wr1_warp,
    input  logic [INSTR_W-1:0]           wr1_data,
    output logic [NUM_WARPS-1:0]         req_if,
    input  logic [NUM_WARPS-1:0]         flush,
    output logic [NUM_WARPS-1:0]         head_valid,
    output logic [NUM_WARPS*INSTR_W-1:0] head_data,
    input  logic [NUM_WARPS-1:0]         ready_scb,
    output logic                         issue_valid,
    output logic [LOGNUM_WARPS-1:0]      issue_warp,
    output logic [INSTR_W-1:0]           issue_data,
    input  logic                         issue_stall,
    output logic                         overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]           count    [NUM_WARPS];
    logic [INSTR_W-1:0]      head_arr [NUM_WARPS];
    logic [NUM_WARPS-1:0]    ovf, pop, eligible;
    logic [LOGNUM_WARPS-1:0] rr_ptr, winner, rr_next;
    logic [INSTR_W-1:0]      sel_data;
    logic                    found, adv;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        ibuffer_mq_warp_fifo #(
            .DEPTH   (DEPTH),
            .INSTR_W (INSTR_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push0      (wr0_valid && (wr0_warp == LOGNUM_WARPS'(g))),
            .push1      (wr1_valid && (wr1_warp == LOGNUM_WARPS'(g))),
            .data0      (wr0_data),
            .data1      (wr1_data),
            .pop        (pop[g]),
            .flush      (flush[g]),
            .head_valid (head_valid[g]),
            .head_data  (head_arr[g]),
            .count      (count[g]),
            .ovf        (ovf[g])
        );
        assign head_data[g*INSTR_W +: INSTR_W] = head_arr[g];
        assign req_if[g] = (count[g] <= CW'(DEPTH - 2)) && !flush[g];
    end

    assign eligible = head_valid & ready_scb & ~flush;
    assign adv      = !issue_valid || !issue_stall;

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_wrap(int'(rr_ptr) + i, NUM_WARPS);
            if (!found && eligible[LOGNUM_WARPS'(idx)]) begin
                found  = 1'b1;
                winner = LOGNUM_WARPS'(idx);
            end
        end
    end

    assign pop      = (adv && found) ? (NUM_WARPS'(1) << winner) : '0;
    assign sel_data = head_arr[winner];
    assign rr_next  = (winner == LOGNUM_WARPS'(NUM_WARPS - 1)) ? '0 : winner + LOGNUM_WARPS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_warp   <= '0;
            issue_data   <= '0;
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (adv) begin
                issue_valid <= found;
                if (found) begin
                    issue_warp <= winner;
                    issue_data <= sel_data;
                    rr_ptr     <= rr_next;
                end
            end
            overflow_err <= overflow_err | (|ovf);
        end
    end

endmodule

// File: doc/ibuffer_mq.md
# ibuffer_mq

Parametrised multi-queue instruction buffer: one DEPTH-entry FIFO per warp, fed by the dual decode stage, gated by per-warp scoreboard readiness, and drained by a round-robin issue arbiter into a registered, stallable output stage toward the operand collector. It replaces the fixed single-entry per-warp buffering with configurable depth, dual same-cycle deposit, per-warp flush and backpressure from the operand collector.

## Interface
- NUM_WARPS, 8, number of warp queues
- DEPTH, 4, entries per warp queue (>=2, need not be a power of two)
- INSTR_W, 64, width of the opaque decoded instruction bundle
- LOGNUM_WARPS, $clog2(NUM_WARPS), warp ID width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr0_valid / wr1_valid  in  1  decode slot 0/1 deposits an instruction
- wr0_warp / wr1_warp  in  LOGNUM_WARPS  target warp of slot 0/1
- wr0_data / wr1_data  in  INSTR_W  decoded bundle of slot 0/1
- req_if  out  NUM_WARPS  warp w may be fetched (queue has room for 2)
- flush  in  NUM_WARPS  drop all queued entries of warp w (SIMT drop / exit)
- head_valid  out  NUM_WARPS  warp w queue non-empty
- head_data  out  NUM_WARPS*INSTR_W  flattened head bundle per warp, to scoreboard
- ready_scb  in  NUM_WARPS  scoreboard: head of warp w is hazard-free
- issue_valid  out  1  issue register holds a valid instruction
- issue_warp  out  LOGNUM_WARPS  warp of issued instruction
- issue_data  out  INSTR_W  issued bundle
- issue_stall  in  1  operand collector cannot accept this cycle
- overflow_err  out  1  sticky: a deposit hit a full queue

## Operation
- Per-warp queue: rd pointer, wr pointer, count of width $clog2(DEPTH+1); pointers wrap DEPTH-1 -> 0 explicitly.
- Deposit: slot 0 written before slot 1; both slots may target the same warp (two entries, order 0 then 1, count +2). Deposit into a full queue is dropped and sets overflow_err (cleared only by rst). With one free slot and two writes to that warp, slot 0 lands, slot 1 is dropped and flags.
- req_if[w] = (count[w] <= DEPTH-2) && !flush[w]; combinational from registered count.
- Eligible[w] = head_valid[w] && ready_scb[w] && !flush[w].
- Advance condition: adv = !issue_valid || !issue_stall.
- On adv: round-robin pick the first eligible warp starting at rr_ptr; pop its head, load issue register (valid, warp, data), rr_ptr <= winner+1 (mod NUM_WARPS). No eligible warp on adv: issue_valid <= 0, rr_ptr unchanged.
- When !adv: issue register holds, no pop, rr_ptr holds.
- Flush[w]: rd=wr=count=0 next cycle; same-cycle deposits to w dropped (no overflow flag); w not selectable that cycle. An instruction of w already in the issue register is not recalled.
- Same-cycle pop and deposit on one warp: count += deposits - 1; a deposit into a queue full at cycle start is dropped even if the head pops that cycle.

## Timing
- Reset values: all counts/pointers 0, rr_ptr 0, issue_valid 0, issue_warp 0, issue_data 0, overflow_err 0; hence head_valid 0, req_if all 1.
- Deposit at edge N -> head_valid visible after N (empty queue: head_data valid in cycle N+1).
- Selection combinational in cycle N, issue_valid/data registered at edge N+1; minimum deposit-to-issue latency 2 cycles.
- Throughput: one issue per cycle with no stall; back-to-back same-warp issue allowed when it is the only eligible warp.
- Reset asserted mid-operation: all state cleared asynchronously, in-flight issue discarded.

## Structure
- Shared package/header: INSTR_W default, field offsets within the bundle (src/dst/valid bits for scoreboard decode), DEPTH default.
- Sub-module ibuffer_mq_warp_fifo: dual-push, single-pop, flush, overflow flag; instantiated NUM_WARPS times in a generate loop. Arbiter and issue register live in the top.

## Test plan
- Reset, deposit warp 3 via wr0 at cycle 1, ready_scb all 1 -> issue_valid=1, issue_warp=3 at edge 3, head_valid[3]=0 after.
- DEPTH=4, two dual deposits to warp 0 -> count 4, req_if[0]=0; fifth deposit -> dropped, overflow_err=1 and stays 1.
- Warps 1,2,5 one entry each, all ready -> issue order 1,2,5 on consecutive cycles; rr_ptr ends at 6.
- Warp 2 has 3 entries, issue_stall=1 for 3 cycles with issue_valid=1 -> output held, count[2] unchanged; release -> entries issue in deposit order.
- flush[4] same cycle as wr0/wr1 to warp 4 with 2 queued -> count[4]=0, no overflow, req_if[4]=1 next cycle.
- ready_scb[6]=0 with warp 6 queued -> never issued; raising it -> issued within 2 cycles.
